tron_plot_arbiter: RTL and testbench



---
 rtl/tron_pkg.sv | 20 ++
 rtl/tron_board_ram.sv | 15 +
 rtl/tron_plot_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_tron_plot_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// tron_pkg: shared constants for the tron plot arbiter and its board RAM
package tron_pkg;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int ADDR_W = 15;
  localparam logic [7:0] X_LAST = 8'(SCR_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCR_H - 1);
  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DEAD = 3'd4;
  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_A = 2'b01;
  localparam logic [1:0] WINNER_B = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] cx, input logic [6:0] cy);
    return {cy, cx};
  endfunction
endpackage

// File: rtl/tron_board_ram.sv
// tron_board_ram: 32768x1 synchronous single-port occupancy RAM, 1-cycle read latency
module tron_board_ram import tron_pkg::*; (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic              din,
  output logic              dout
);
  logic mem [0:(1<<ADDR_W)-1];
  // read-before-write port; storage needs no reset since the clear sweep zeroes every used cell
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/tron_plot_arbiter.sv
// tron_plot_arbiter: shares the VGA plot port between two tron players and owns the collision board
module tron_plot_arbiter import tron_pkg::*; #(
  parameter logic [7:0] X_MIN = 8'd10,
  parameter logic [7:0] X_MAX = 8'd149,
  parameter logic [6:0] Y_MIN = 7'd17,
  parameter logic [6:0] Y_MAX = 7'd108,
  parameter logic [2:0] COLOUR_A = 3'b001,
  parameter logic [2:0] COLOUR_B = 3'b100,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter logic [2:0] WALL_COLOUR = 3'b111
) (
  input  logic       clk_out_half,
  input  logic       resetn,
  input  logic       step_a,
  input  logic [7:0] pos_a_x,
  input  logic [6:0] pos_a_y,
  input  logic       step_b,
  input  logic [7:0] pos_b_x,
  input  logic [6:0] pos_b_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       ready,
  output logic       dead,
  output logic [1:0] winner
);
  logic [2:0] state_q, state_d;
  logic [7:0] sx_q, sx_d, ax_q, ax_d, bx_q, bx_d, gx_q, gx_d, x_q, x_d;
  logic [6:0] sy_q, sy_d, ay_q, ay_d, by_q, by_d, gy_q, gy_d, y_q, y_d;
  logic pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic rr_q, rr_d, gnt_q, gnt_d;
  logic [2:0] colour_q, colour_d;
  logic plot_q, plot_d, ready_q, ready_d, dead_q, dead_d;
  logic [1:0] winner_q, winner_d;
  logic ram_we, ram_din, ram_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic live, pick_b, draw, occupied, clr, wr;
  logic [7:0] sel_x;
  logic [6:0] sel_y;

  function automatic logic is_wall(input logic [7:0] px, input logic [6:0] py);
    return ((px == X_MIN || px == X_MAX) && py >= Y_MIN && py <= Y_MAX) ||
           ((py == Y_MIN || py == Y_MAX) && px >= X_MIN && px <= X_MAX);
  endfunction

  function automatic logic is_out(input logic [7:0] px, input logic [6:0] py);
    return px < X_MIN || px > X_MAX || py < Y_MIN || py > Y_MAX;
  endfunction

  tron_board_ram u_ram (
    .clk(clk_out_half),
    .we(ram_we),
    .addr(ram_addr),
    .din(ram_din),
    .dout(ram_dout)
  );

  // step capture and round-robin selection; rr_q = 1 means B was served last so A is preferred
  always_comb begin
    live = state_q == S_IDLE || state_q == S_CHECK || state_q == S_WRITE;
    pend_a_d = (live && step_a) || (pend_a_q && !(state_q == S_WRITE && !gnt_q));
    pend_b_d = (live && step_b) || (pend_b_q && !(state_q == S_WRITE && gnt_q));
    ax_d = live && step_a ? pos_a_x : ax_q;
    ay_d = live && step_a ? pos_a_y : ay_q;
    bx_d = live && step_b ? pos_b_x : bx_q;
    by_d = live && step_b ? pos_b_y : by_q;
    pick_b = pend_b_q && (!pend_a_q || !rr_q);
    draw = pend_a_q && pend_b_q && ax_q == bx_q && ay_q == by_q;
    sel_x = pick_b ? bx_q : ax_q;
    sel_y = pick_b ? by_q : ay_q;
    occupied = ram_dout || is_wall(gx_q, gy_q) || is_out(gx_q, gy_q);
  end

  // sequencer: clear sweep, then read/check/write per granted step until someone dies
  always_comb begin
    state_d = state_q;
    sx_d = sx_q;
    sy_d = sy_q;
    gnt_d = gnt_q;
    gx_d = gx_q;
    gy_d = gy_q;
    rr_d = rr_q;
    dead_d = dead_q;
    winner_d = winner_q;
    ram_we = 1'b0;
    ram_din = 1'b0;
    ram_addr = cell_addr(gx_q, gy_q);
    case (state_q)
      S_CLEAR: begin
        ram_we = 1'b1;
        ram_addr = cell_addr(sx_q, sy_q);
        sx_d = sx_q == X_LAST ? 8'd0 : sx_q + 8'd1;
        sy_d = sx_q == X_LAST ? sy_q + 7'd1 : sy_q;
        state_d = sx_q == X_LAST && sy_q == Y_LAST ? S_IDLE : S_CLEAR;
      end
      S_IDLE: begin
        ram_addr = cell_addr(sel_x, sel_y);
        if (draw) begin
          dead_d = 1'b1;
          winner_d = WINNER_DRAW;
          state_d = S_DEAD;
        end else if (pend_a_q || pend_b_q) begin
          gnt_d = pick_b;
          gx_d = sel_x;
          gy_d = sel_y;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        dead_d = occupied;
        winner_d = occupied ? (gnt_q ? WINNER_A : WINNER_B) : winner_q;
        state_d = occupied ? S_DEAD : S_WRITE;
      end
      S_WRITE: begin
        ram_we = 1'b1;
        ram_din = 1'b1;
        rr_d = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_DEAD;
    endcase
  end

  // registered VGA port: clear pixels during the sweep, trail pixels in WRITE, otherwise hold with plot low
  always_comb begin
    clr = state_q == S_CLEAR;
    wr = state_q == S_WRITE;
    plot_d = clr || wr;
    x_d = clr ? sx_q : wr ? gx_q : x_q;
    y_d = clr ? sy_q : wr ? gy_q : y_q;
    colour_d = clr ? (is_wall(sx_q, sy_q) ? WALL_COLOUR : BG_COLOUR) :
               wr ? (gnt_q ? COLOUR_B : COLOUR_A) : colour_q;
    ready_d = !clr;
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk_out_half) begin
    if (!resetn) begin
      state_q <= S_CLEAR;
      sx_q <= '0;
      sy_q <= '0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      ax_q <= '0;
      ay_q <= '0;
      bx_q <= '0;
      by_q <= '0;
      rr_q <= 1'b1;
      gnt_q <= 1'b0;
      gx_q <= '0;
      gy_q <= '0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
      plot_q <= 1'b0;
      ready_q <= 1'b0;
      dead_q <= 1'b0;
      winner_q <= WINNER_NONE;
    end else begin
      state_q <= state_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      ax_q <= ax_d;
      ay_q <= ay_d;
      bx_q <= bx_d;
      by_q <= by_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      gx_q <= gx_d;
      gy_q <= gy_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
      plot_q <= plot_d;
      ready_q <= ready_d;
      dead_q <= dead_d;
      winner_q <= winner_d;
    end
  end

  assign x = x_q;
  assign y = y_q;
  assign colour = colour_q;
  assign plot = plot_q;
  assign ready = ready_q;
  assign dead = dead_q;
  assign winner = winner_q;
endmodule

// File: tb/tb_tron_plot_arbiter.sv
// tb_tron_plot_arbiter: directed bench with a pixel-stream model of the arbiter
module tb_tron_plot_arbiter;
  logic clk_out_half = 1'b0;
  logic resetn = 1'b0;
  logic step_a = 1'b0, step_b = 1'b0;
  logic [7:0] pos_a_x = '0, pos_b_x = '0, x;
  logic [6:0] pos_a_y = '0, pos_b_y = '0, y;
  logic [2:0] colour;
  logic plot, ready, dead;
  logic [1:0] winner;

  tron_plot_arbiter dut (
    .clk_out_half(clk_out_half), .resetn(resetn),
    .step_a(step_a), .pos_a_x(pos_a_x), .pos_a_y(pos_a_y),
    .step_b(step_b), .pos_b_x(pos_b_x), .pos_b_y(pos_b_y),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .ready(ready), .dead(dead), .winner(winner)
  );

  always #5 clk_out_half = ~clk_out_half;

  typedef struct {logic [7:0] x; logic [6:0] y; logic [2:0] c;} px_t;
  px_t expq[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, plot_count = 0, last_plot_cyc = -1, prev_plot_cyc = -1;
  logic [2:0] seen [0:119][0:159];
  bit mb [0:159][0:119];
  bit m_dead, m_rr_b;
  logic [1:0] m_win;

  function automatic bit m_wall(int px, int py);
    return ((px == 10 || px == 149) && py >= 17 && py <= 108) ||
           ((py == 17 || py == 108) && px >= 10 && px <= 149);
  endfunction

  // a cell is free only strictly inside the wall rectangle
  function automatic bit m_blocked(int px, int py);
    return px <= 10 || px >= 149 || py <= 17 || py >= 108;
  endfunction

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_out_half);
    cyc++;
  end

  // every plotted pixel must be the next one the model predicts
  initial forever begin
    @(negedge clk_out_half);
    if (plot === 1'b1) begin
      plot_count++;
      prev_plot_cyc = last_plot_cyc;
      last_plot_cyc = cyc;
      if (x < 160 && y < 120) seen[y][x] = colour;
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0h expected no plot", x, y, colour);
      end else begin
        px_t e;
        e = expq.pop_front();
        check("plot_pixel", int'({x, y, colour}), int'({e.x, e.y, e.c}));
      end
    end
  end

  task automatic m_serve(bit p_b, int px, int py);
    if (m_dead) return;
    if (m_blocked(px, py) || mb[px][py]) begin
      m_dead = 1'b1;
      m_win = p_b ? 2'b01 : 2'b10;
    end else begin
      expq.push_back('{8'(px), 7'(py), p_b ? 3'b100 : 3'b001});
      mb[px][py] = 1'b1;
      m_rr_b = p_b;
    end
  endtask

  task automatic do_reset();
    @(posedge clk_out_half);
    #2 resetn = 1'b0;
    step_a = 1'b0;
    step_b = 1'b0;
    @(posedge clk_out_half);
    @(posedge clk_out_half);
    #2 resetn = 1'b1;
    expq.delete();
    plot_count = 0;
    for (int j = 0; j < 120; j++)
      for (int i = 0; i < 160; i++) begin
        expq.push_back('{8'(i), 7'(j), m_wall(i, j) ? 3'b111 : 3'b000});
        mb[i][j] = 1'b0;
      end
    m_dead = 1'b0;
    m_win = 2'b00;
    m_rr_b = 1'b1;
    @(negedge clk_out_half);
    #1;
    check("rst_plot", int'(plot), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_dead_winner", int'({dead, winner}), 0);
    check("rst_xyc", int'({x, y, colour}), 0);
  endtask

  task automatic wait_ready();
    bit got = 1'b0;
    for (int i = 0; i < 19400 && !got; i++) begin
      @(negedge clk_out_half);
      #1;
      if (ready) got = 1'b1;
    end
    check("ready_seen", int'(got), 1);
    check("ready_after_last_plot", last_plot_cyc, cyc - 1);
    check("clear_plot_count", plot_count, 19200);
    check("clear_queue_left", expq.size(), 0);
  endtask

  task automatic apply(bit sa, bit sb, int ax, int ay, int bx, int by, output int k);
    @(posedge clk_out_half);
    #2;
    step_a = sa;
    step_b = sb;
    pos_a_x = 8'(ax);
    pos_a_y = 7'(ay);
    pos_b_x = 8'(bx);
    pos_b_y = 7'(by);
    @(posedge clk_out_half);
    #1;
    k = cyc;
    step_a = 1'b0;
    step_b = 1'b0;
    if (!m_dead) begin
      if (sa && sb && ax == bx && ay == by) begin
        m_dead = 1'b1;
        m_win = 2'b11;
      end else if (sa && sb) begin
        if (m_rr_b) begin m_serve(0, ax, ay); m_serve(1, bx, by); end
        else begin m_serve(1, bx, by); m_serve(0, ax, ay); end
      end else if (sa) m_serve(0, ax, ay);
      else if (sb) m_serve(1, bx, by);
    end
    repeat (12) @(negedge clk_out_half);
    #1;
    check("status_dead", int'(dead), int'(m_dead));
    check("status_winner", int'(winner), int'(m_win));
    check("pending_plots", expq.size(), 0);
  endtask

  initial begin
    int k, pc;
    do_reset();
    wait_ready();
    check("wall_10_17", int'(seen[17][10]), 7);
    check("wall_149_108", int'(seen[108][149]), 7);
    check("bg_60_60", int'(seen[60][60]), 0);
    check("bg_0_0", int'(seen[0][0]), 0);

    apply(1, 0, 25, 100, 0, 0, k);
    check("a_latency", last_plot_cyc, k + 3);
    check("a_colour", int'(seen[100][25]), 1);
    check("a_alive", int'(dead), 0);

    apply(0, 1, 0, 0, 120, 90, k);
    check("b_colour", int'(seen[90][120]), 4);

    apply(1, 1, 30, 50, 100, 50, k);
    check("rr_first_a", prev_plot_cyc, k + 3);
    check("rr_then_b", last_plot_cyc, k + 6);
    check("rr_b_colour", int'(seen[50][100]), 4);

    apply(1, 0, 40, 70, 0, 0, k);
    pc = plot_count;
    apply(0, 1, 0, 0, 40, 70, k);
    check("trail_hit_winner", int'({dead, winner}), 3'b101);
    check("trail_hit_noplot", plot_count, pc);

    do_reset();
    wait_ready();
    pc = plot_count;
    apply(1, 1, 80, 60, 80, 60, k);
    check("draw_winner", int'({dead, winner}), 3'b111);
    check("draw_noplot", plot_count, pc);

    do_reset();
    wait_ready();
    pc = plot_count;
    apply(1, 0, 10, 40, 0, 0, k);
    check("wall_winner", int'({dead, winner}), 3'b110);
    apply(1, 0, 50, 50, 0, 0, k);
    apply(0, 1, 0, 0, 60, 60, k);
    check("dead_noplot", plot_count, pc);

    do_reset();
    repeat (99) @(negedge clk_out_half);
    #1;
    check("restart_plots", plot_count, 99);
    check("restart_ready", int'(ready), 0);
    check("restart_dead", int'({dead, winner}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
